ifft_out_reorder: RTL and testbench
===================================

// Module: ifft_out_reorder
// PURPOSE
//  Output stage directly downstream of ifft. Captures each 32-point complex frame
//  streamed on ifft's pushout/dor/doi into a ping-pong buffer. Replays the frame
//  to the consumer in natural order (bit-reversal undo) with a ready/valid
//  handshake, so the consumer may stall without the ifft stalling.
// PARAMETERS
//  N      32  points per frame, power of two; counters are log2(N) bits
//  W      28  width of each real/imag sample
//  BITREV 1   1: read address = bit-reverse(read count); 0: read in write order
// PORTS
//  clk      in   1  rising-edge clock
//  rst      in   1  asynchronous, active-high reset
//  pushin   in   1  sample valid; driven by ifft pushout
//  dir      in   W  real input sample; driven by ifft dor
//  dii      in   W  imaginary input sample; driven by ifft doi
//  readyin  in   1  consumer can accept a sample this cycle
//  pushout  out  1  dor/doi hold a valid sample
//  dor      out  W  real output sample
//  doi      out  W  imaginary output sample
//  lastout  out  1  qualifies pushout: this is sample N-1 of the frame
//  overflow out  1  sticky: an input sample was dropped
// BEHAVIOUR
//  Reset (async, any time, including mid-frame): pushout=0, dor=0, doi=0,
//   lastout=0, overflow=0. Write count, read count, bank-full flags and bank
//   pointers go to 0. RAM contents are not cleared.
//  Storage: 2 banks x N entries x 2W bits. Each bank has a full flag.
//  Write side: pushin=1 writes {dir,dii} to wbank[wcnt], then wcnt++.
//   - Write at wcnt==N-1: set full[wbank], toggle wbank, wcnt=0.
//   - Gate check at wcnt==0 only: if full[wbank] is set and that bank is not
//     releasing on this edge, drop the whole frame. Set overflow, let wcnt count
//     through N samples, and write nothing. The next frame re-checks the gate.
//   - Simultaneous events: a bank whose last sample is read on this edge counts
//     as free, so its first write on the same edge is allowed.
//  Read side: FSM IDLE / DRAIN.
//   - IDLE: go to DRAIN when full[rbank]=1; rcnt=0.
//   - DRAIN: the output register loads rbank[addr] when (!pushout || readyin).
//     addr = BITREV ? bitrev(rcnt) : rcnt. rcnt++ on each load.
//   - Load at rcnt==N-1: set lastout with that sample, clear full[rbank],
//     toggle rbank. Then go to IDLE, or stay in DRAIN with rcnt=0 if the other
//     bank is already full (no bubble).
//   - pushout falls when the register is consumed (readyin=1) and no new load
//     occurs.
//  Handshake: a transfer happens on an edge with pushout&&readyin. While
//   pushout=1 and readyin=0, dor/doi/lastout are held stable.
//  Latency: last input sample written at edge E; with readyin=1, output 0 is
//   visible after edge E+1. Afterwards one sample per cycle.
//  Throughput: continuous pushin with readyin=1 never overflows.
//  Arithmetic: none. Data are passed bit-exact. Counters wrap modulo N.
// TESTING
//  1 Impulse: pushin one frame with sample 1={1000000,0800000}h, rest 0,
//    readyin=1, BITREV=1 -> 32 outputs, only output 16 nonzero
//    ={1000000,0800000}h. lastout on output 31. overflow=0.
//  2 Back-to-back: 64 consecutive pushin (ramp dir=k, dii=~k), readyin=1 ->
//    64 contiguous pushout cycles, no bubble between frames. Output j of frame f
//    = input f*32+bitrev(j). lastout at outputs 31 and 63.
//  3 Backpressure: drop readyin for 10 cycles at output 7 -> dor/doi/pushout
//    frozen for 10 cycles. Stream resumes at output 8. No sample lost or
//    repeated.
//  4 Overflow: readyin=0, push 3 frames (values 1xx, 2xx, 3xx) -> overflow=1 from
//    the first sample of frame 3. Raise readyin -> frames 1 and 2 emerge intact,
//    frame 3 is never output.
//  5 Reset mid-drain: assert rst at output 12 -> pushout/overflow/lastout=0
//    immediately, without waiting for a clock edge. After release, a fresh frame
//    outputs correctly from index 0.
//  6 BITREV=0 build: single ramp frame (dir=k) -> outputs dor=0..31 in order.

Source files
------------

// File: rtl/ifft_out_reorder.sv
// ifft_out_reorder: ping-pong frame buffer that replays ifft output frames in natural
// order through a ready/valid output register, dropping whole frames when both banks are busy.
module ifft_out_reorder #(
  parameter int N      = 32,
  parameter int W      = 28,
  parameter bit BITREV = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         pushin,
  input  logic [W-1:0] dir,
  input  logic [W-1:0] dii,
  input  logic         readyin,
  output logic         pushout,
  output logic [W-1:0] dor,
  output logic [W-1:0] doi,
  output logic         lastout,
  output logic         overflow
);
  localparam int LG = $clog2(N);
  typedef enum logic {IDLE, DRAIN} state_t;
  logic [2*W-1:0] mem [2][N];
  logic [2*W-1:0] rdata;
  state_t state_q, state_d;
  logic [LG-1:0] wcnt_q, wcnt_d, rcnt_q, rcnt_d, raddr;
  logic wbank_q, wbank_d, rbank_q, rbank_d;
  logic drop_q, drop_d, ovf_q, ovf_d;
  logic [1:0] full_q, full_d;
  logic pout_q, pout_d, last_q, last_d;
  logic [W-1:0] dor_q, dor_d, doi_q, doi_d;
  logic load, rlast, release_b, wfirst, wlast, drop, we;
  always_comb begin
    raddr = '0;
    for (int i = 0; i < LG; i++) raddr[i] = BITREV ? rcnt_q[LG-1-i] : rcnt_q[i];
  end
  assign rdata = mem[rbank_q][raddr];
  // IDLE loads as soon as a bank fills so output 0 follows the last write by one edge
  assign load = (state_q == DRAIN || full_q[rbank_q]) && (!pout_q || readyin);
  assign rlast = rcnt_q == LG'(N - 1);
  assign release_b = load && rlast;
  assign wfirst = wcnt_q == '0;
  assign wlast = wcnt_q == LG'(N - 1);
  // a bank emptying on this edge is free for the first write of the next frame
  assign drop = wfirst ? (full_q[wbank_q] && !(release_b && rbank_q == wbank_q)) : drop_q;
  assign we = pushin && !drop;
  always_comb begin
    state_d = state_q;
    wcnt_d = wcnt_q;
    rcnt_d = rcnt_q;
    wbank_d = wbank_q;
    rbank_d = rbank_q;
    drop_d = drop_q;
    ovf_d = ovf_q;
    full_d = full_q;
    pout_d = pout_q;
    last_d = last_q;
    dor_d = dor_q;
    doi_d = doi_q;
    if (state_q == IDLE && full_q[rbank_q]) state_d = DRAIN;
    if (load) begin
      pout_d = 1'b1;
      dor_d = rdata[2*W-1:W];
      doi_d = rdata[W-1:0];
      last_d = rlast;
      rcnt_d = rcnt_q + 1'b1;
    end else if (readyin) begin
      pout_d = 1'b0;
      last_d = 1'b0;
    end
    if (release_b) begin
      full_d[rbank_q] = 1'b0;
      rbank_d = !rbank_q;
      state_d = full_q[!rbank_q] ? DRAIN : IDLE;
    end
    if (pushin) begin
      wcnt_d = wcnt_q + 1'b1;
      drop_d = drop;
      ovf_d = ovf_q | drop;
      if (wlast && !drop) begin
        full_d[wbank_q] = 1'b1;
        wbank_d = !wbank_q;
      end
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      wcnt_q <= '0;
      rcnt_q <= '0;
      wbank_q <= 1'b0;
      rbank_q <= 1'b0;
      drop_q <= 1'b0;
      ovf_q <= 1'b0;
      full_q <= '0;
      pout_q <= 1'b0;
      last_q <= 1'b0;
      dor_q <= '0;
      doi_q <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q <= wcnt_d;
      rcnt_q <= rcnt_d;
      wbank_q <= wbank_d;
      rbank_q <= rbank_d;
      drop_q <= drop_d;
      ovf_q <= ovf_d;
      full_q <= full_d;
      pout_q <= pout_d;
      last_q <= last_d;
      dor_q <= dor_d;
      doi_q <= doi_d;
    end
  end
  always_ff @(posedge clk) if (we) mem[wbank_q][wcnt_q] <= {dir, dii};
  assign pushout = pout_q;
  assign dor = dor_q;
  assign doi = doi_q;
  assign lastout = last_q;
  assign overflow = ovf_q;
endmodule

// File: tb/tb_ifft_out_reorder.sv
// tb_ifft_out_reorder: scoreboard bench for the reorder buffer, with a second BITREV=0 instance.
module tb_ifft_out_reorder;
  localparam int N = 32;
  localparam int W = 28;
  typedef logic [2*W:0] exp_t;
  logic clk = 1'b0, rst, pushin, readyin;
  logic [W-1:0] dir, dii, dor0, doi0, dor1, doi1;
  logic pushout0, lastout0, overflow0, pushout1, lastout1, overflow1;
  exp_t sb[$], sb0[$];
  int checks = 0, errors = 0;

  ifft_out_reorder #(.N(N), .W(W), .BITREV(1'b1)) u0 (
    .clk(clk), .rst(rst), .pushin(pushin), .dir(dir), .dii(dii), .readyin(readyin),
    .pushout(pushout0), .dor(dor0), .doi(doi0), .lastout(lastout0), .overflow(overflow0));
  ifft_out_reorder #(.N(N), .W(W), .BITREV(1'b0)) u1 (
    .clk(clk), .rst(rst), .pushin(pushin), .dir(dir), .dii(dii), .readyin(readyin),
    .pushout(pushout1), .dor(dor1), .doi(doi1), .lastout(lastout1), .overflow(overflow1));

  always #5 clk = ~clk;

  function automatic int brev(input int j);
    int r = 0;
    for (int i = 0; i < 5; i++) r[i] = j[4-i];
    return r;
  endfunction

  // called at posedge+1; returns at posedge+1 after the last write edge
  task automatic push_frame(input logic [W-1:0] rv [N], input logic [W-1:0] iv [N], input bit keep);
    for (int k = 0; k < N; k++) begin
      pushin = 1'b1;
      dir = rv[k];
      dii = iv[k];
      if (k == N - 1 && keep)
        for (int j = 0; j < N; j++) begin
          sb.push_back({rv[brev(j)], iv[brev(j)], j == N - 1});
          sb0.push_back({rv[j], iv[j], j == N - 1});
        end
      @(posedge clk); #1;
    end
    pushin = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; pushin = 1'b0; readyin = 1'b0; dir = '0; dii = '0;
    @(posedge clk); #1;
    checks++;
    if ({pushout0, dor0, doi0, lastout0, overflow0} !== '0) begin
      errors++; $display("FAIL reset_u0 got %h exp 0", {pushout0, dor0, doi0, lastout0, overflow0});
    end
    checks++;
    if ({pushout1, dor1, doi1, lastout1, overflow1} !== '0) begin
      errors++; $display("FAIL reset_u1 got %h exp 0", {pushout1, dor1, doi1, lastout1, overflow1});
    end
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (pushout0 !== 1'b0) begin errors++; $display("FAIL idle_pushout got %b exp 0", pushout0); end
  endtask

  task automatic test_impulse;
    logic [W-1:0] rv [N], iv [N];
    int got = 0, cyc = 0, first = -1;
    exp_t e;
    sb.delete(); sb0.delete();
    for (int k = 0; k < N; k++) begin rv[k] = '0; iv[k] = '0; end
    rv[1] = 28'h1000000; iv[1] = 28'h0800000;
    readyin = 1'b1;
    @(posedge clk); #1;
    push_frame(rv, iv, 1'b1);
    while (got < N && cyc < 200) begin
      @(negedge clk); cyc++;
      if (pushout0 && readyin) begin
        if (first < 0) first = cyc;
        e = sb.size() ? sb.pop_front() : 'x;
        checks++;
        if ({dor0, doi0, lastout0} !== e) begin
          errors++; $display("FAIL impulse_out%0d got %h exp %h", got, {dor0, doi0, lastout0}, e);
        end
        got++;
      end
    end
    checks++;
    if (got != N) begin errors++; $display("FAIL impulse_count got %0d exp %0d", got, N); end
    checks++;
    if (first != 2) begin errors++; $display("FAIL impulse_latency got %0d exp 2", first); end
    checks++;
    if (overflow0 !== 1'b0) begin errors++; $display("FAIL impulse_overflow got %b exp 0", overflow0); end
  endtask

  task automatic test_back_to_back;
    logic [W-1:0] ra [N], ia [N], rb [N], ib [N];
    int got = 0, cyc = 0, first = -1, last = -1;
    exp_t e;
    sb.delete(); sb0.delete();
    for (int k = 0; k < N; k++) begin
      ra[k] = W'(k); ia[k] = ~W'(k);
      rb[k] = W'(k + N); ib[k] = ~W'(k + N);
    end
    readyin = 1'b1;
    @(posedge clk); #1;
    fork
      begin push_frame(ra, ia, 1'b1); push_frame(rb, ib, 1'b1); end
      while (got < 2 * N && cyc < 300) begin
        @(negedge clk); cyc++;
        if (pushout0 && readyin) begin
          if (first < 0) first = cyc;
          last = cyc;
          e = sb.size() ? sb.pop_front() : 'x;
          checks++;
          if ({dor0, doi0, lastout0} !== e) begin
            errors++; $display("FAIL b2b_out%0d got %h exp %h", got, {dor0, doi0, lastout0}, e);
          end
          got++;
        end
      end
    join
    checks++;
    if (got != 2 * N) begin errors++; $display("FAIL b2b_count got %0d exp %0d", got, 2 * N); end
    checks++;
    if (last - first != 2 * N - 1) begin
      errors++; $display("FAIL b2b_contiguous got span %0d exp %0d", last - first, 2 * N - 1);
    end
  endtask

  task automatic test_backpressure;
    logic [W-1:0] rv [N], iv [N];
    int got = 0, cyc = 0;
    bit stalled = 1'b0;
    exp_t e;
    sb.delete(); sb0.delete();
    for (int k = 0; k < N; k++) begin rv[k] = W'($urandom); iv[k] = W'($urandom); end
    readyin = 1'b1;
    @(posedge clk); #1;
    push_frame(rv, iv, 1'b1);
    while (got < N && cyc < 300) begin
      @(negedge clk); cyc++;
      if (pushout0 && got == 7 && !stalled) begin
        stalled = 1'b1;
        readyin = 1'b0;
        repeat (10) begin
          @(negedge clk);
          checks++;
          if (!(pushout0 === 1'b1 && {dor0, doi0, lastout0} === sb[0])) begin
            errors++; $display("FAIL stall_hold got %b %h exp 1 %h", pushout0, {dor0, doi0, lastout0}, sb[0]);
          end
        end
        readyin = 1'b1;
      end
      if (pushout0 && readyin) begin
        e = sb.size() ? sb.pop_front() : 'x;
        checks++;
        if ({dor0, doi0, lastout0} !== e) begin
          errors++; $display("FAIL bp_out%0d got %h exp %h", got, {dor0, doi0, lastout0}, e);
        end
        got++;
      end
    end
    checks++;
    if (got != N || !stalled) begin errors++; $display("FAIL bp_count got %0d exp %0d", got, N); end
  endtask

  task automatic test_overflow;
    logic [W-1:0] r1 [N], r2 [N], r3 [N];
    int got = 0, cyc = 0, stray = 0;
    exp_t e;
    sb.delete(); sb0.delete();
    for (int k = 0; k < N; k++) begin
      r1[k] = W'(32'h100 + k); r2[k] = W'(32'h200 + k); r3[k] = W'(32'h300 + k);
    end
    @(posedge clk); #1;
    readyin = 1'b0;
    push_frame(r1, r1, 1'b1);
    push_frame(r2, r2, 1'b1);
    checks++;
    if (overflow0 !== 1'b0) begin errors++; $display("FAIL ovf_early got %b exp 0", overflow0); end
    fork
      push_frame(r3, r3, 1'b0);
      begin
        @(posedge clk); @(posedge clk); @(negedge clk);
        checks++;
        if (overflow0 !== 1'b1) begin errors++; $display("FAIL ovf_first_sample got %b exp 1", overflow0); end
      end
    join
    readyin = 1'b1;
    while (got < 2 * N && cyc < 300) begin
      @(negedge clk); cyc++;
      if (pushout0 && readyin) begin
        e = sb.size() ? sb.pop_front() : 'x;
        checks++;
        if ({dor0, doi0, lastout0} !== e) begin
          errors++; $display("FAIL ovf_out%0d got %h exp %h", got, {dor0, doi0, lastout0}, e);
        end
        got++;
      end
    end
    checks++;
    if (got != 2 * N) begin errors++; $display("FAIL ovf_count got %0d exp %0d", got, 2 * N); end
    repeat (40) begin
      @(negedge clk);
      if (pushout0) stray++;
    end
    checks++;
    if (stray != 0) begin errors++; $display("FAIL ovf_frame3_emitted got %0d exp 0", stray); end
    checks++;
    if (overflow0 !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b exp 1", overflow0); end
  endtask

  task automatic test_reset_mid_drain;
    logic [W-1:0] rv [N], iv [N];
    int got = 0, cyc = 0;
    exp_t e;
    sb.delete(); sb0.delete();
    for (int k = 0; k < N; k++) begin rv[k] = W'($urandom); iv[k] = W'($urandom); end
    readyin = 1'b1;
    @(posedge clk); #1;
    push_frame(rv, iv, 1'b1);
    while (got < 12 && cyc < 200) begin
      @(negedge clk); cyc++;
      if (pushout0 && readyin) begin void'(sb.pop_front()); got++; end
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({pushout0, lastout0, overflow0, dor0, doi0} !== '0) begin
      errors++; $display("FAIL async_reset got %h exp 0", {pushout0, lastout0, overflow0, dor0, doi0});
    end
    checks++;
    if (pushout1 !== 1'b0) begin errors++; $display("FAIL async_reset_u1 got %b exp 0", pushout1); end
    @(posedge clk); #1;
    rst = 1'b0;
    sb.delete(); sb0.delete();
    got = 0; cyc = 0;
    for (int k = 0; k < N; k++) begin rv[k] = W'($urandom); iv[k] = W'($urandom); end
    push_frame(rv, iv, 1'b1);
    while (got < N && cyc < 200) begin
      @(negedge clk); cyc++;
      if (pushout0 && readyin) begin
        e = sb.size() ? sb.pop_front() : 'x;
        checks++;
        if ({dor0, doi0, lastout0} !== e) begin
          errors++; $display("FAIL post_reset_out%0d got %h exp %h", got, {dor0, doi0, lastout0}, e);
        end
        got++;
      end
    end
    checks++;
    if (got != N) begin errors++; $display("FAIL post_reset_count got %0d exp %0d", got, N); end
  endtask

  task automatic test_natural_order;
    logic [W-1:0] rv [N], iv [N];
    int got = 0, cyc = 0;
    exp_t e;
    sb.delete(); sb0.delete();
    for (int k = 0; k < N; k++) begin rv[k] = W'(k); iv[k] = W'(32'h5000 + k); end
    readyin = 1'b1;
    @(posedge clk); #1;
    push_frame(rv, iv, 1'b1);
    while (got < N && cyc < 200) begin
      @(negedge clk); cyc++;
      if (pushout1 && readyin) begin
        e = sb0.size() ? sb0.pop_front() : 'x;
        checks++;
        if ({dor1, doi1, lastout1} !== e) begin
          errors++; $display("FAIL natural_out%0d got %h exp %h", got, {dor1, doi1, lastout1}, e);
        end
        got++;
      end
    end
    checks++;
    if (got != N) begin errors++; $display("FAIL natural_count got %0d exp %0d", got, N); end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_impulse();
    test_back_to_back();
    test_backpressure();
    test_overflow();
    test_reset_mid_drain();
    test_natural_order();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
